drug_delivery_sequencer: RTL

- Sequences one drug administration at a time for the heart monitoring system: IV line setup, then timed pump infusion, then saline flush, then a refractory lockout.
- Sits between the tachycardia decision logic (dose request plus dosage) and the actuator enables.
- Enforces a cumulative dose ceiling.
- Aborts safely when CPR becomes active.

---
 rtl/drug_seq_pkg.sv | 22 ++
 rtl/drug_delivery_sequencer_phase_timer.sv | 27 ++
 rtl/drug_delivery_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/drug_seq_pkg.sv
// Shared types and default timing constants for the drug delivery sequencer.
// States, phase lengths and the cumulative-dose width are kept here so the top and the bench agree.
package drug_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IV_SETUP,
        INFUSE,
        FLUSH,
        LOCKOUT
    } seq_state_t;

    localparam int DEF_IV_SETUP_CYCLES = 4;
    localparam int DEF_UNIT_CYCLES     = 2;
    localparam int DEF_FLUSH_CYCLES    = 3;
    localparam int DEF_LOCKOUT_CYCLES  = 8;
    localparam int DEF_MAX_CUM_DOSE    = 24;

    localparam int CUM_W   = 8;
    localparam int TIMER_W = 8;

endpackage

// File: rtl/drug_delivery_sequencer_phase_timer.sv
// Loadable down-counter that measures the length of one sequencer phase.
// expire is high during the last cycle of a loaded interval, so the FSM can leave on that edge.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/drug_delivery_sequencer.sv
// Sequences one drug administration: IV setup, timed infusion, saline flush, refractory lockout.
// Enforces a cumulative dose ceiling and aborts safely when CPR starts.
module drug_delivery_sequencer
    import drug_seq_pkg::*;
#(
    parameter int IV_SETUP_CYCLES = DEF_IV_SETUP_CYCLES,
    parameter int UNIT_CYCLES     = DEF_UNIT_CYCLES,
    parameter int FLUSH_CYCLES    = DEF_FLUSH_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int MAX_CUM_DOSE    = DEF_MAX_CUM_DOSE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dose_req,
    input  logic [3:0]       dose_units,
    input  logic             cpr_active,
    input  logic             dose_clear,
    output logic             dose_ack,
    output logic             dose_reject,
    output logic             iv_line_setup,
    output logic             pump_enable,
    output logic             saline_flush,
    output logic             busy,
    output logic             dose_done,
    output logic             dose_abort,
    output logic [CUM_W-1:0] cum_dose
);

    localparam logic [TIMER_W-1:0] IV_LOAD      = IV_SETUP_CYCLES[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] UNIT_LOAD    = UNIT_CYCLES[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] UNIT_LAST    = UNIT_LOAD - 1'b1;
    localparam logic [TIMER_W-1:0] FLUSH_LOAD   = FLUSH_CYCLES[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = LOCKOUT_CYCLES[TIMER_W-1:0];
    localparam logic [CUM_W:0]     CUM_LIMIT    = MAX_CUM_DOSE[CUM_W:0];

    seq_state_t         state;
    seq_state_t         state_next;
    logic [3:0]         dose_latched;
    logic [3:0]         dose_latched_next;
    logic               abort_flag;
    logic               abort_flag_next;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expire;
    logic               ack_next;
    logic               reject_next;
    logic               done_next;
    logic               abort_next;
    logic               clear_cum;
    logic [CUM_W-1:0]   cum_base;
    logic [CUM_W:0]     cum_sum;
    logic [TIMER_W-1:0] unit_cnt;
    logic               unit_boundary;

    phase_timer #(
        .WIDTH(TIMER_W)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .expire    (timer_expire)
    );

    // A clear on the same edge as a request makes the limit check start from zero.
    assign cum_base      = dose_clear ? '0 : cum_dose;
    assign cum_sum       = {1'b0, cum_base} + {{(CUM_W-3){1'b0}}, dose_units};
    assign unit_boundary = (state == INFUSE) && (unit_cnt == UNIT_LAST);

    always_comb begin
        state_next        = state;
        dose_latched_next = dose_latched;
        abort_flag_next   = abort_flag;
        timer_load        = 1'b0;
        timer_value       = '0;
        ack_next          = 1'b0;
        reject_next       = 1'b0;
        done_next         = 1'b0;
        abort_next        = 1'b0;
        clear_cum         = 1'b0;

        case (state)
            IDLE: begin
                clear_cum       = dose_clear;
                abort_flag_next = 1'b0;
                if (!cpr_active && dose_req) begin
                    if ((dose_units != 4'd0) && (cum_sum <= CUM_LIMIT)) begin
                        ack_next          = 1'b1;
                        dose_latched_next = dose_units;
                        state_next        = IV_SETUP;
                        timer_load        = 1'b1;
                        timer_value       = IV_LOAD;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end

            // No drug has flowed yet, so a CPR abort here skips flush and lockout.
            IV_SETUP: begin
                if (cpr_active) begin
                    state_next = IDLE;
                    abort_next = 1'b1;
                end else if (timer_expire) begin
                    state_next  = INFUSE;
                    timer_load  = 1'b1;
                    timer_value = {4'b0, dose_latched} * UNIT_LOAD;
                end
            end

            INFUSE: begin
                if (cpr_active || timer_expire) begin
                    state_next      = FLUSH;
                    abort_flag_next = abort_flag | cpr_active;
                    timer_load      = 1'b1;
                    timer_value     = FLUSH_LOAD;
                end
            end

            FLUSH: begin
                if (timer_expire) begin
                    state_next  = LOCKOUT;
                    done_next   = !abort_flag;
                    abort_next  = abort_flag;
                    timer_load  = 1'b1;
                    timer_value = LOCKOUT_LOAD;
                end
            end

            LOCKOUT: begin
                if (timer_expire) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched request and every output are registered together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            dose_latched  <= '0;
            abort_flag    <= 1'b0;
            dose_ack      <= 1'b0;
            dose_reject   <= 1'b0;
            iv_line_setup <= 1'b0;
            pump_enable   <= 1'b0;
            saline_flush  <= 1'b0;
            busy          <= 1'b0;
            dose_done     <= 1'b0;
            dose_abort    <= 1'b0;
        end else begin
            state         <= state_next;
            dose_latched  <= dose_latched_next;
            abort_flag    <= abort_flag_next;
            dose_ack      <= ack_next;
            dose_reject   <= reject_next;
            iv_line_setup <= (state_next == IV_SETUP);
            pump_enable   <= (state_next == INFUSE);
            saline_flush  <= (state_next == FLUSH);
            busy          <= (state_next != IDLE);
            dose_done     <= done_next;
            dose_abort    <= abort_next;
        end
    end

    // Only whole units are credited; a partial unit cut short by an abort is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            unit_cnt <= '0;
            cum_dose <= '0;
        end else begin
            if (state == INFUSE) begin
                unit_cnt <= unit_boundary ? '0 : unit_cnt + 1'b1;
            end else begin
                unit_cnt <= '0;
            end
            if (clear_cum) begin
                cum_dose <= '0;
            end else if (unit_boundary && ({1'b0, cum_dose} < CUM_LIMIT)) begin
                cum_dose <= cum_dose + 1'b1;
            end
        end
    end

endmodule
